// File: rtl/rs_132_120_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the RS(132,120) decoder front end.
// Field: primitive polynomial 0x11D, alpha = 0x02.
package rs_132_120_pkg;

    localparam int N    = 132;
    localparam int K    = 120;
    localparam int NPAR = 12;
    localparam int FCR  = 0;

    localparam logic [8:0] GF_POLY = 9'h11D;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } synd_state_t;

    typedef logic [NPAR-1:0][7:0] root_tbl_t;

    // General GF(2^8) multiply; with one constant operand it folds to an XOR network.
    function automatic logic [7:0] gf256mul_dec(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            if (aa[7]) begin
                aa = {aa[6:0], 1'b0} ^ GF_POLY[7:0];
            end else begin
                aa = {aa[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) begin
            r = gf256mul_dec(r, 8'h02);
        end
        return r;
    endfunction

    function automatic root_tbl_t build_roots();
        root_tbl_t t;
        for (int j = 0; j < NPAR; j++) begin
            t[j] = gf_alpha_pow(FCR + j);
        end
        return t;
    endfunction

    // alpha^(FCR+j): the evaluation point of syndrome j
    localparam root_tbl_t ALPHA_ROOTS = build_roots();

endpackage

// File: rtl/rs_synd_cell.sv
// One Horner accumulator: acc <= acc*ROOT ^ din on update, acc <= din on load.
// acc_nxt exposes the updated value so the caller can capture the final syndrome without a bubble.
module rs_synd_cell
    import rs_132_120_pkg::*;
#(
    parameter logic [7:0] ROOT = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       update,
    input  logic [7:0] din,
    output logic [7:0] acc_nxt
);

    logic [7:0] acc_r;

    assign acc_nxt = gf256mul_dec(acc_r, ROOT) ^ din;

    // Accumulator register: start a new codeword on load, fold one symbol in on update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 8'h00;
        end else if (load) begin
            acc_r <= din;
        end else if (update) begin
            acc_r <= acc_nxt;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/rs_syndrome_132_120.sv
// RS(132,120) syndrome generator with frame policing.
// Optional delivery statistics (frm_cnt, bad_cnt) are built when RS_SYND_STATS_EN is defined.
module rs_syndrome_132_120
    import rs_132_120_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din_val,
    input  logic                din_sop,
    input  logic                din_eop,
    input  logic [7:0]          din,
    output logic                synd_val,
    output logic [NPAR*8-1:0]   synd,
    output logic                err_flag,
    output logic                frame_err
`ifdef RS_SYND_STATS_EN
    ,
    output logic [15:0]         frm_cnt,
    output logic [15:0]         bad_cnt
`endif
);

    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    synd_state_t          state_r;
    logic [7:0]           cnt_r;
    logic [NPAR*8-1:0]    synd_r;
    logic [NPAR*8-1:0]    acc_nxt_s;
    logic                 synd_val_r;
    logic                 err_flag_r;
    logic                 frame_err_r;
    logic                 load_s;
    logic                 update_s;
    logic                 restart_s;
    logic                 complete_s;
    logic                 early_s;

    for (genvar j = 0; j < NPAR; j++) begin : g_cell
        rs_synd_cell #(.ROOT(ALPHA_ROOTS[j])) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load_s),
            .update  (update_s),
            .din     (din),
            .acc_nxt (acc_nxt_s[8*j +: 8])
        );
    end

    // Symbol classification: sop always wins over eop and over completion.
    always_comb begin
        load_s     = 1'b0;
        update_s   = 1'b0;
        restart_s  = 1'b0;
        complete_s = 1'b0;
        early_s    = 1'b0;
        if (din_val && din_sop) begin
            load_s    = 1'b1;
            restart_s = (state_r == RECV);
        end else if (din_val && (state_r == RECV)) begin
            update_s   = 1'b1;
            complete_s = (cnt_r == LAST_CNT);
            early_s    = (cnt_r != LAST_CNT) && din_eop;
        end else begin
            load_s   = 1'b0;
            update_s = 1'b0;
        end
    end

    // Frame FSM, symbol counter and registered syndrome outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            synd_r      <= '0;
            synd_val_r  <= 1'b0;
            err_flag_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            synd_val_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        cnt_r   <= 8'd1;
                        state_r <= RECV;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                RECV: begin
                    if (restart_s) begin
                        cnt_r       <= 8'd1;
                        frame_err_r <= 1'b1;
                    end else if (complete_s) begin
                        synd_r      <= acc_nxt_s;
                        err_flag_r  <= |acc_nxt_s;
                        synd_val_r  <= 1'b1;
                        frame_err_r <= ~din_eop;
                        cnt_r       <= 8'd0;
                        state_r     <= IDLE;
                    end else if (early_s) begin
                        frame_err_r <= 1'b1;
                        cnt_r       <= 8'd0;
                        state_r     <= IDLE;
                    end else if (update_s) begin
                        cnt_r <= cnt_r + 8'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    assign synd_val  = synd_val_r;
    assign synd      = synd_r;
    assign err_flag  = err_flag_r;
    assign frame_err = frame_err_r;

`ifdef RS_SYND_STATS_EN
    logic [15:0] frm_cnt_r;
    logic [15:0] bad_cnt_r;

    // Saturating delivery counters, driven from the registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_r <= 16'h0000;
            bad_cnt_r <= 16'h0000;
        end else begin
            if (synd_val_r && (frm_cnt_r != 16'hFFFF)) begin
                frm_cnt_r <= frm_cnt_r + 16'h0001;
            end else begin
                frm_cnt_r <= frm_cnt_r;
            end
            if (((synd_val_r && err_flag_r) || frame_err_r) && (bad_cnt_r != 16'hFFFF)) begin
                bad_cnt_r <= bad_cnt_r + 16'h0001;
            end else begin
                bad_cnt_r <= bad_cnt_r;
            end
        end
    end

    assign frm_cnt = frm_cnt_r;
    assign bad_cnt = bad_cnt_r;
`endif

endmodule

// File: tb/tb_rs_syndrome_132_120.sv
// Scoreboard bench for rs_syndrome_132_120: a driver queues expected pulses, a monitor pops and checks.
// Reference syndromes are direct polynomial evaluations of the received frame.
module tb_rs_syndrome_132_120;

    localparam int NS    = 132;
    localparam int NP    = 12;
    localparam int FCR_M = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_val = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        synd_val;
    logic [95:0] synd;
    logic        err_flag;
    logic        frame_err;
`ifdef RS_SYND_STATS_EN
    logic [15:0] frm_cnt;
    logic [15:0] bad_cnt;
`endif

    rs_syndrome_132_120 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_val   (din_val),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .din       (din),
        .synd_val  (synd_val),
        .synd      (synd),
        .err_flag  (err_flag),
        .frame_err (frame_err)
`ifdef RS_SYND_STATS_EN
        ,
        .frm_cnt   (frm_cnt),
        .bad_cnt   (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          has_synd;
        logic [95:0] synd;
        bit          ferr;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    int          nchk = 0;
    int          nbad = 0;
    int          exp_frm = 0;
    int          exp_bad = 0;
    bit          partial_open = 1'b0;
    logic [95:0] last_synd = '0;
    logic [7:0]  frm[NS];
    logic [7:0]  gexp[255];
    logic [7:0]  gen[NP+1];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] expv);
        nchk++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // S_j = sum_i r_i * alpha^((FCR+j)*(131-i)), evaluated term by term
    function automatic logic [95:0] ref_synd();
        logic [95:0] s = '0;
        for (int j = 0; j < NP; j++) begin
            logic [7:0] acc = 8'h00;
            for (int i = 0; i < NS; i++) begin
                acc ^= gmul(frm[i], gexp[((FCR_M + j) * (NS - 1 - i)) % 255]);
            end
            s[8*j +: 8] = acc;
        end
        return s;
    endfunction

    task automatic build_tables();
        gexp[0] = 8'h01;
        for (int i = 1; i < 255; i++) gexp[i] = gmul(gexp[i-1], 8'h02);
        for (int k = 0; k <= NP; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        for (int r = 0; r < NP; r++) begin
            for (int k = r + 1; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], gexp[FCR_M + r]);
            gen[0] = gmul(gen[0], gexp[FCR_M + r]);
        end
    endtask

    // Systematic codeword: data 0x01..0x78 followed by remainder of m(x)*x^12 mod g(x)
    task automatic encode_frame();
        logic [7:0] rem[NP];
        logic [7:0] fb;
        for (int k = 0; k < NP; k++) rem[k] = 8'h00;
        for (int i = 0; i < NS - NP; i++) begin
            frm[i] = 8'(i + 1);
            fb = frm[i] ^ rem[NP-1];
            for (int k = NP - 1; k >= 1; k--) rem[k] = rem[k-1] ^ gmul(fb, gen[k]);
            rem[0] = gmul(fb, gen[0]);
        end
        for (int k = 0; k < NP; k++) frm[NS - NP + k] = rem[NP - 1 - k];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_val = 1'b0;
            din     = 8'($urandom);
            din_sop = 1'($urandom);
            din_eop = 1'($urandom);
        end
    endtask

    task automatic drive_sym(input logic [7:0] d, input bit s, input bit e, output int c);
        @(negedge clk);
        din_val = 1'b1;
        din     = d;
        din_sop = s;
        din_eop = e;
        c = cyc;
    endtask

    task automatic push_ferr(input int c);
        exp_t e;
        e.has_synd = 1'b0; e.synd = '0; e.ferr = 1'b1; e.cyc = c + 1;
        expq.push_back(e);
        exp_bad++;
    endtask

    // gapmode: 0 contiguous, 1 one idle after every symbol, 2 random 0..2 idles
    task automatic send_frame(input int len, input int gapmode, input bit with_eop);
        int c;
        exp_t e;
        logic [95:0] s;
        s = ref_synd();
        for (int i = 0; i < len; i++) begin
            drive_sym(frm[i], i == 0, (i == len - 1) && with_eop, c);
            if (i == 0 && partial_open) push_ferr(c);
            if (i == len - 1) begin
                if (len == NS) begin
                    e.has_synd = 1'b1; e.synd = s; e.ferr = !with_eop; e.cyc = c + 1;
                    expq.push_back(e);
                    exp_frm++;
                    if ((|s) || !with_eop) exp_bad++;
                    partial_open = 1'b0;
                end else if (with_eop) begin
                    push_ferr(c);
                    partial_open = 1'b0;
                end else begin
                    partial_open = 1'b1;
                end
            end
            if (gapmode == 1) idle(1);
            else if (gapmode == 2) idle($urandom_range(0, 2));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_synd"}, synd, '0);
        check({tag, "_synd_val"}, synd_val, 1'b0);
        check({tag, "_err_flag"}, err_flag, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (synd_val || frame_err)) begin
            if (expq.size() == 0) begin
                nchk++;
                nbad++;
                $display("FAIL unexpected_pulse: synd_val=%b frame_err=%b at cycle %0d, none expected",
                         synd_val, frame_err, cyc);
            end else begin
                e = expq.pop_front();
                check("pulse_cycle", 96'(cyc), 96'(e.cyc));
                check("synd_val", synd_val, e.has_synd);
                check("frame_err", frame_err, e.ferr);
                if (e.has_synd) begin
                    check("synd", synd, e.synd);
                    check("err_flag", err_flag, |e.synd);
                    last_synd = e.synd;
                end
            end
        end
    end

    initial begin
        int c;
        build_tables();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // all-zero codeword
        for (int i = 0; i < NS; i++) frm[i] = 8'h00;
        send_frame(NS, 0, 1);
        idle(3);

        // clean codeword, contiguous then with every-other-cycle gaps
        encode_frame();
        send_frame(NS, 0, 1);
        idle(2);
        send_frame(NS, 1, 1);
        idle(3);

        // corrupt the final symbol: every S_j becomes 0x5A
        frm[NS-1] ^= 8'h5A;
        send_frame(NS, 0, 1);
        idle(3);
        check("synd_hold", synd, last_synd);
        encode_frame();

        // stray symbols without sop are ignored in IDLE
        for (int i = 0; i < 3; i++) drive_sym(8'($urandom), 1'b0, 1'($urandom), c);
        idle(2);

        // early eop, then a good frame
        send_frame(100, 0, 1);
        idle(2);
        send_frame(NS, 0, 1);
        idle(2);

        // sop re-asserted at symbol 50
        send_frame(49, 0, 0);
        send_frame(NS, 0, 1);
        idle(2);

        // back-to-back frames, then a completing symbol without eop
        send_frame(NS, 0, 1);
        send_frame(NS, 0, 1);
        send_frame(NS, 0, 0);
        idle(3);

        // randomized frames: random words or codewords with scattered errors
        for (int r = 0; r < 6; r++) begin
            encode_frame();
            if (r % 2 == 0) begin
                for (int i = 0; i < NS; i++) frm[i] = 8'($urandom);
            end else begin
                for (int k = 0; k < $urandom_range(0, 3); k++)
                    frm[$urandom_range(0, NS - 1)] ^= 8'($urandom_range(1, 255));
            end
            send_frame(NS, 2, $urandom_range(0, 3) != 0);
            idle($urandom_range(0, 1));
        end
        idle(3);

`ifdef RS_SYND_STATS_EN
        check("frm_cnt", frm_cnt, exp_frm);
        check("bad_cnt", bad_cnt, exp_bad);
`endif

        // reset mid-frame: everything clears, no pulses
        encode_frame();
        send_frame(70, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        din_val = 1'b0;
        #1;
        check_outputs_zero("midreset");
        partial_open = 1'b0;
        exp_frm = 0;
        exp_bad = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check_outputs_zero("post_reset");

        // recovery frame after reset
        send_frame(NS, 0, 1);
        for (int w = 0; w < 10 && expq.size() != 0; w++) idle(1);
        idle(2);
        check("queue_drained", 96'(expq.size()), 96'd0);
`ifdef RS_SYND_STATS_EN
        check("frm_cnt_after_reset", frm_cnt, exp_frm);
        check("bad_cnt_after_reset", bad_cnt, exp_bad);
`endif

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
